seq_detector: RTL and testbench

//  Parametrised, programmable serial sequence detector (Moore-style, registered output).
//  - Generalises the fixed '1101' Moore detector: run-time pattern (1..MAX_LEN bits), run-time length,

---
 rtl/seq_detector_pkg.sv | 20 ++
 rtl/seq_detector_window.sv | 49 ++++
 rtl/seq_detector.sv | 89 ++++++++
 tb/tb_seq_detector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_detector_pkg;

    localparam int MAX_LEN_DEF = 8;

    typedef enum logic {
        MODE_NOOVL = 1'b0,
        MODE_OVL   = 1'b1
    } match_mode_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Lengths of 0 or beyond the window collapse to the full window.
    function automatic int clamp_len(input int len, input int max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detector_window.sv
// History shift register, saturating fill counter and masked pattern comparator.
module seq_window
    import seq_detector_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               sample_i,
    input  logic               flush_i,
    input  logic               bit_i,
    input  match_mode_e        mode_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

    // hit_o looks at the window as it will be after this bit shifts in.
    always_comb begin
        hist_d   = {hist_q[MAX_LEN-2:0], bit_i};
        fill_inc = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
        for (int k = 0; k < MAX_LEN; k++) begin
            mask[k] = (k < int'(len_i));
        end
        hit_o  = (fill_inc == len_i) && (((hist_d ^ pattern_i) & mask) == '0);
        fill_d = fill_inc;
        if (hit_o && (mode_i == MODE_NOOVL)) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (flush_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (sample_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Programmable serial sequence detector with registered one-cycle match flag.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int                 MAX_LEN     = MAX_LEN_DEF,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1101),
    parameter int                 DEF_LEN     = 4,
    parameter int                 CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i,
    input  logic                       in_en,
    input  logic                       overlap,
    input  logic                       pat_load,
    input  logic [MAX_LEN-1:0]         pat_in,
    input  logic [len_w(MAX_LEN)-1:0]  pat_len,
    input  logic                       cnt_clr,
    output logic                       o,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               o_q, o_d;
    logic               sample, hit;
    match_mode_e        mode;

    assign sample = in_en & ~pat_load;
    assign mode   = overlap ? MODE_OVL : MODE_NOOVL;
    assign len_d  = LEN_W'(clamp_len(int'(pat_len), MAX_LEN));
    assign o_d    = pat_load ? 1'b0 : (in_en & hit);

    seq_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk       (clk),
        .n_rst     (n_rst),
        .sample_i  (sample),
        .flush_i   (pat_load),
        .bit_i     (i),
        .mode_i    (mode),
        .len_i     (len_q),
        .pattern_i (pattern_q),
        .hit_o     (hit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
            o_q       <= 1'b0;
        end else begin
            if (pat_load) begin
                pattern_q <= pat_in;
                len_q     <= len_d;
            end
            o_q <= o_d;
        end
    end

    assign o = o_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over a coincident hit; the count sticks at all-ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (sample && hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: bit-queue reference model, directed and random stimulus.
module tb_seq_detector;

`ifdef SEQDET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             i = 1'b0;
    logic             in_en = 1'b0;
    logic             overlap = 1'b1;
    logic             pat_load = 1'b0;
    logic [7:0]       pat_in = '0;
    logic [3:0]       pat_len = '0;
    logic             cnt_clr = 1'b0;
    logic             o;
    logic [CNT_W-1:0] match_cnt;

    seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .i         (i),
        .in_en     (in_en),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .pat_len   (pat_len),
        .cnt_clr   (cnt_clr),
        .o         (o),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the bits received since the last flush, newest at the back.
    bit   q[$];
    logic [7:0] m_pat = 8'b1101;
    int   m_len = 4;
    int   exp_o = 0;
    int   exp_cnt = 0;
    int   lit_o = -1;
    int   lit_cnt = -1;

    int   n_tests = 0;
    int   n_fail = 0;

    function automatic bit tail_matches();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat   = 8'b1101;
        m_len   = 4;
        exp_o   = 0;
        exp_cnt = 0;
    endtask

    task automatic model_edge();
        bit h;
        h = 1'b0;
        if (pat_load) begin
            m_pat = pat_in;
            m_len = ((pat_len == 0) || (int'(pat_len) > MAX_LEN)) ? MAX_LEN : int'(pat_len);
            q.delete();
        end else if (in_en) begin
            q.push_back(i);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            h = tail_matches();
            if (h && !overlap) q.delete();
        end
        exp_o = h ? 1 : 0;
        if (CNT_ON) begin
            if (cnt_clr) exp_cnt = 0;
            else if (h && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
        end
    endtask

    function automatic void check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, expv, $time);
        end
    endfunction

    // Single compare process: model every edge, plus literal pins when requested.
    always @(posedge clk or negedge n_rst) begin
        #1;
        check("o", int'(o), exp_o);
        check("match_cnt", int'(match_cnt), exp_cnt);
        if (lit_o >= 0)   check("lit_o", int'(o), lit_o);
        if (lit_cnt >= 0) check("lit_cnt", int'(match_cnt), lit_cnt);
    end

    task automatic step(input bit b, input bit en = 1'b1, input bit ld = 1'b0,
                        input bit clr = 1'b0, input int lo = -1, input int lc = -1);
        @(negedge clk);
        i        = b;
        in_en    = en;
        pat_load = ld;
        cnt_clr  = clr;
        lit_o    = lo;
        lit_cnt  = lc;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n, input logic [15:0] hits,
                            input int final_cnt);
        for (int k = 0; k < n; k++) begin
            step(bits[n-1-k], 1'b1, 1'b0, 1'b0, int'(hits[n-1-k]),
                 (k == n - 1) ? final_cnt : -1);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit clr);
        pat_in  = p;
        pat_len = l;
        step(1'b1, 1'b1, 1'b1, clr, 0, clr ? 0 : -1);
    endtask

    task automatic do_reset();
        model_reset();
        lit_o   = 0;
        lit_cnt = 0;
        n_rst   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst   = 1'b1;
        lit_o   = -1;
        lit_cnt = -1;
    endtask

    initial begin
        // Power-on reset held across edges
        lit_o = 0;
        lit_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        lit_o = -1;
        lit_cnt = -1;

        // Default 1101, overlapping
        overlap = 1'b1;
        run_bits(16'b1101101, 7, 16'b0001001, CNT_ON ? 2 : 0);

        // Same stream, non-overlapping
        load(8'b1101, 4'd4, 1'b1);
        overlap = 1'b0;
        run_bits(16'b1101101, 7, 16'b0001000, CNT_ON ? 1 : 0);

        // Constant streams never match
        load(8'b1101, 4'd4, 1'b1);
        run_bits(16'h0000, 10, 16'h0000, 0);
        run_bits(16'h03FF, 10, 16'h0000, 0);

        // Loaded 101 pattern, overlapping; load mid-stream kills the partial match
        overlap = 1'b1;
        load(8'b101, 4'd3, 1'b1);
        run_bits(16'b10101, 5, 16'b00101, CNT_ON ? 2 : 0);
        load(8'b101, 4'd3, 1'b0);
        run_bits(16'b10, 2, 16'b00, -1);
        load(8'b101, 4'd3, 1'b0);
        run_bits(16'b1, 1, 16'b0, -1);
        run_bits(16'b01, 2, 16'b01, -1);

        // Qualifier low between pattern bits
        load(8'b1101, 4'd4, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, CNT_ON ? 1 : 0);

        // Five matches saturate a 2-bit counter; clear beats a coincident hit
        load(8'b1101, 4'd4, 1'b1);
        run_bits(16'b1101101101101101, 16, 16'b0001001001001001, CNT_ON ? 3 : 0);
        step(1'b1);
        step(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1, 0);

        // Length 1, and length 0 clamping to the full window
        overlap = 1'b0;
        load(8'h01, 4'd1, 1'b1);
        run_bits(16'b1011, 4, 16'b1011, CNT_ON ? 3 : 0);
        overlap = 1'b1;
        load(8'hA5, 4'd0, 1'b1);
        run_bits(16'b1010010110100101, 16, 16'b0000000100000001, -1);

        // Mid-cycle reset while o is high restores the default pattern
        load(8'b101, 4'd3, 1'b1);
        run_bits(16'b101, 3, 16'b001, -1);
        do_reset();
        run_bits(16'b1101, 4, 16'b0001, CNT_ON ? 1 : 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) overlap = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                pat_in  = 8'($urandom);
                pat_len = 4'($urandom_range(0, 15));
                step(1'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 49) == 0);
            end else begin
                step(1'($urandom), $urandom_range(0, 9) != 0, 1'b0, $urandom_range(0, 49) == 0);
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
